// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
// dds_sweep_ctrl: drives the DDS we/data tuning port, stepping the tuning word from start to stop
// with a programmable dwell per word. Define DDS_SWEEP_KEY_EN to add a debounced push-button start/stop.
module dds_sweep_ctrl #(
  parameter int PHASE_W      = 29,
  parameter int DWELL_W      = 24,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] start_word,
  input  logic [PHASE_W-1:0] stop_word,
  input  logic [PHASE_W-1:0] step_word,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               continuous,
  input  logic               sweep_start,
  input  logic               sweep_stop,
  input  logic               key_n,
  output logic               dds_we,
  output logic [PHASE_W-1:0] dds_data,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DWELL, S_STEP, S_DONE} state_t;

  state_t             state, state_nx;
  logic [PHASE_W-1:0] cfg_start, cfg_stop, cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_valid;
  logic [PHASE_W-1:0] cur, cur_nx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [PHASE_W:0]   step_sum;
  logic               start_req, stop_req;
  logic               cfg_bad;
  logic               we_d, busy_d, done_d, err_d;

  // Start/stop request sources
`ifdef DDS_SWEEP_KEY_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]      key_sync;
  logic [DB_W-1:0] db_cnt;
  logic            key_evt;

  // db_cnt saturates at DEBOUNCE_CYC so a held key yields exactly one event until released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync <= '0;
      db_cnt   <= '0;
      key_evt  <= 1'b0;
    end else begin
      key_sync <= {key_sync[0], key_n};
      key_evt  <= key_sync[1] && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
      if (!key_sync[1])
        db_cnt <= '0;
      else if (db_cnt != DB_W'(DEBOUNCE_CYC))
        db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign start_req = sweep_start | (key_evt & (state == S_IDLE));
  assign stop_req  = sweep_stop  | (key_evt & (state != S_IDLE));
`else
  logic [31:0] unused_key;
  assign unused_key = 32'(DEBOUNCE_CYC) ^ {31'b0, key_n};
  assign start_req  = sweep_start;
  assign stop_req   = sweep_stop;
`endif

  assign cfg_bad = (start_word > stop_word) || (step_word == '0);

  // Configuration registers, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
      cfg_valid <= 1'b0;
    end else if (cfg_load && state == S_IDLE && !cfg_bad) begin
      cfg_start <= start_word;
      cfg_stop  <= stop_word;
      cfg_step  <= step_word;
      cfg_dwell <= dwell_cycles;
      cfg_valid <= 1'b1;
    end
  end

  // State register, current word and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      dwell_cnt <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      if (state == S_WRITE)
        dwell_cnt <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
      else if (state == S_DWELL)
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
    end
  end

  // Next state; the extra sum bit keeps a carry out of PHASE_W from wrapping past stop
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    step_sum = {1'b0, cur} + {1'b0, cfg_step};
    case (state)
      S_IDLE:  if (start_req && cfg_valid) begin
                 cur_nx   = cfg_start;
                 state_nx = S_WRITE;
               end
      S_WRITE: state_nx = S_DWELL;
      S_DWELL: if (dwell_cnt <= DWELL_W'(1)) state_nx = S_STEP;
      S_STEP:  if (step_sum <= {1'b0, cfg_stop}) begin
                 cur_nx   = step_sum[PHASE_W-1:0];
                 state_nx = S_WRITE;
               end else if (continuous) begin
                 cur_nx   = cfg_start;
                 state_nx = S_WRITE;
               end else begin
                 state_nx = S_DONE;
               end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (stop_req) begin
      state_nx = S_IDLE;
      cur_nx   = cur;
    end
  end

  // Outputs decoded from the next state so the registered copies line up with it
  always_comb begin
    we_d   = (state_nx == S_WRITE);
    busy_d = (state_nx != S_IDLE);
    done_d = (state_nx == S_DONE);
    err_d  = cfg_load && (state == S_IDLE) && cfg_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dds_we     <= 1'b0;
      dds_data   <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      dds_we     <= we_d;
      busy       <= busy_d;
      sweep_done <= done_d;
      cfg_err    <= err_d;
      if (we_d) dds_data <= cur_nx;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Directed table-driven bench for dds_sweep_ctrl; key tests adapt to DDS_SWEEP_KEY_EN.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_load, continuous, sweep_start, sweep_stop, key_n;
  logic [28:0] start_word, stop_word, step_word;
  logic [23:0] dwell_cycles;
  logic        dds_we, busy, sweep_done, cfg_err;
  logic [28:0] dds_data;

  dds_sweep_ctrl #(.PHASE_W(29), .DWELL_W(24), .DEBOUNCE_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .start_word(start_word),
    .stop_word(stop_word), .step_word(step_word), .dwell_cycles(dwell_cycles),
    .continuous(continuous), .sweep_start(sweep_start), .sweep_stop(sweep_stop),
    .key_n(key_n), .dds_we(dds_we), .dds_data(dds_data), .busy(busy),
    .sweep_done(sweep_done), .cfg_err(cfg_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          tst;
    int          cyc;
    logic        we;
    logic [28:0] data;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  int          total = 0;
  int          bad   = 0;
  int          wcnt;
  logic        cap_we[0:63], cap_busy[0:63], cap_done[0:63], cap_err[0:63];
  logic [28:0] cap_data[0:63];

  localparam logic [28:0] TOP3 = 29'h1FFF_FFFD;

  function automatic vec_t mk(int t, int c, logic w, logic [28:0] d, logic b, logic dn, logic er);
    vec_t v;
    v.tst = t; v.cyc = c; v.we = w; v.data = d; v.busy = b; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // cfg_load pulse; returns sampled in the following cycle
  task automatic load(input logic [28:0] s, e, st, input logic [23:0] d, input logic exp_err, input string nm);
    @(negedge clk);
    start_word = s; stop_word = e; step_word = st; dwell_cycles = d; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk(nm, {31'b0, cfg_err}, {31'b0, exp_err});
  endtask

  // sweep_start (optionally with sweep_stop) in cycle 0, then capture cycles 1..n
  task automatic run(input int n, input int stop_at, input int load_at, input logic stop0);
    wcnt = 0;
    @(negedge clk);
    sweep_start = 1'b1; sweep_stop = stop0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      sweep_start = 1'b0;
      sweep_stop  = (c == stop_at);
      cfg_load    = (c == load_at);
      cap_we[c] = dds_we; cap_data[c] = dds_data; cap_busy[c] = busy;
      cap_done[c] = sweep_done; cap_err[c] = cfg_err;
      if (dds_we) wcnt++;
    end
    sweep_stop = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic check_tbl(input int t);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].tst == t) begin
        chk($sformatf("t%0d_c%0d_we",   t, tbl[i].cyc), {31'b0, cap_we[tbl[i].cyc]},   {31'b0, tbl[i].we});
        chk($sformatf("t%0d_c%0d_data", t, tbl[i].cyc), {3'b0,  cap_data[tbl[i].cyc]}, {3'b0,  tbl[i].data});
        chk($sformatf("t%0d_c%0d_busy", t, tbl[i].cyc), {31'b0, cap_busy[tbl[i].cyc]}, {31'b0, tbl[i].busy});
        chk($sformatf("t%0d_c%0d_done", t, tbl[i].cyc), {31'b0, cap_done[tbl[i].cyc]}, {31'b0, tbl[i].done});
        chk($sformatf("t%0d_c%0d_err",  t, tbl[i].cyc), {31'b0, cap_err[tbl[i].cyc]},  {31'b0, tbl[i].err});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_we;
    // one-shot 1000..2000 step 500 dwell 4
    tbl.push_back(mk(1,  1, 1, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(1,  2, 0, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(1,  6, 0, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(1,  7, 1, 29'd1500, 1, 0, 0));
    tbl.push_back(mk(1, 13, 1, 29'd2000, 1, 0, 0));
    tbl.push_back(mk(1, 18, 0, 29'd2000, 1, 0, 0));
    tbl.push_back(mk(1, 19, 0, 29'd2000, 1, 1, 0));
    tbl.push_back(mk(1, 20, 0, 29'd2000, 0, 0, 0));
    // continuous, bad cfg_load while busy at 3, stop at 21
    tbl.push_back(mk(2,  1, 1, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(2,  4, 0, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(2,  7, 1, 29'd1500, 1, 0, 0));
    tbl.push_back(mk(2, 13, 1, 29'd2000, 1, 0, 0));
    tbl.push_back(mk(2, 19, 1, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(2, 21, 0, 29'd1000, 1, 0, 0));
    tbl.push_back(mk(2, 22, 0, 29'd1000, 0, 0, 0));
    tbl.push_back(mk(2, 28, 0, 29'd1000, 0, 0, 0));
    // top-of-range one-shot, dwell 0
    tbl.push_back(mk(3,  1, 1, TOP3, 1, 0, 0));
    tbl.push_back(mk(3,  2, 0, TOP3, 1, 0, 0));
    tbl.push_back(mk(3,  3, 0, TOP3, 1, 0, 0));
    tbl.push_back(mk(3,  4, 0, TOP3, 1, 1, 0));
    tbl.push_back(mk(3,  5, 0, TOP3, 0, 0, 0));
    // start and stop together in IDLE
    tbl.push_back(mk(4,  1, 0, TOP3, 0, 0, 0));

    rst_n = 1'b0; cfg_load = 0; continuous = 0; sweep_start = 0; sweep_stop = 0; key_n = 0;
    start_word = '0; stop_word = '0; step_word = '0; dwell_cycles = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_we",   {31'b0, dds_we},     32'd0);
    chk("rst_data", {3'b0, dds_data},    32'd0);
    chk("rst_busy", {31'b0, busy},       32'd0);
    chk("rst_done", {31'b0, sweep_done}, 32'd0);
    chk("rst_err",  {31'b0, cfg_err},    32'd0);

    load(29'd5000, 29'd100, 29'd500, 24'd4, 1'b1, "err_start_gt_stop");
    @(negedge clk);
    chk("err_one_cycle", {31'b0, cfg_err}, 32'd0);
    load(29'd1000, 29'd2000, 29'd0, 24'd4, 1'b1, "err_step_zero");
    run(10, 0, 0, 1'b0);
    chk("novalid_writes", wcnt, 32'd0);
    chk("novalid_busy", {31'b0, cap_busy[1]}, 32'd0);

    load(29'd1000, 29'd2000, 29'd500, 24'd4, 1'b0, "good_load");
    load(29'd1000, 29'd2000, 29'd0, 24'd4, 1'b1, "err_keeps_old");
    run(24, 0, 0, 1'b0);
    check_tbl(1);
    chk("t1_writes", wcnt, 32'd3);

    continuous = 1'b1;
    run(30, 21, 3, 1'b0);
    check_tbl(2);
    chk("t2_writes", wcnt, 32'd4);
    continuous = 1'b0;

    load(TOP3, 29'h1FFF_FFFF, 29'd4, 24'd0, 1'b0, "top_load");
    run(8, 0, 0, 1'b0);
    check_tbl(3);
    chk("t3_writes", wcnt, 32'd1);

    run(5, 0, 0, 1'b1);
    check_tbl(4);
    chk("t4_writes", wcnt, 32'd0);

    // async reset while dwelling
    load(29'd1000, 29'd2000, 29'd500, 24'd4, 1'b0, "rst_mid_load");
    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    chk("pre_rst_data", {3'b0, dds_data}, 32'd1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",   {31'b0, dds_we},  32'd0);
    chk("mid_rst_data", {3'b0, dds_data}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy},    32'd0);
    @(negedge clk); rst_n = 1'b1;

    // push-button behaviour
    continuous = 1'b1;
    load(29'd1000, 29'd2000, 29'd500, 24'd4, 1'b0, "key_load");
    wcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      key_n = (c < 5);
      if (dds_we) wcnt++;
    end
    chk("key_bounce_writes", wcnt, 32'd0);
    chk("key_bounce_busy", {31'b0, busy}, 32'd0);

    first_we = -1;
    wcnt = 0;
    @(negedge clk); key_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 15) key_n = 1'b0;
      if (dds_we) begin
        wcnt++;
        if (first_we < 0) first_we = c;
      end
    end
`ifdef DDS_SWEEP_KEY_EN
    chk("key_first_we", first_we, 32'd13);
    chk("key_run_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); key_n = 1'b1;
    wcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 15) key_n = 1'b0;
      if (c == 11) chk("key_stop_busy_before", {31'b0, busy}, 32'd1);
      if (c == 14) chk("key_stop_busy_after",  {31'b0, busy}, 32'd0);
      if (c >= 14 && dds_we) wcnt++;
    end
    chk("key_stop_writes", wcnt, 32'd0);
`else
    chk("key_ignored_writes", wcnt, 32'd0);
    chk("key_ignored_busy", {31'b0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
